// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: adds WIDTH-bit operands one nibble per cycle through a shared external 4-bit adder
module adder_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);
  localparam int NUM_NIB = WIDTH / 4;
  localparam int IW = NUM_NIB > 1 ? $clog2(NUM_NIB) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic carry_reg;
  logic [IW-1:0] idx;
  logic last;
  always_comb begin
    last = idx == IW'(NUM_NIB - 1);
    add_a = state == ADD ? a_reg[4*idx +: 4] : 4'd0;
    add_b = state == ADD ? b_reg[4*idx +: 4] : 4'd0;
    add_cin = state == ADD ? carry_reg : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry_reg <= 1'b0;
      idx <= '0;
      sum <= '0;
      carry_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= a;
          b_reg <= b;
          carry_reg <= carry_in;
          idx <= '0;
          sum <= '0;
          carry_out <= 1'b0;
          busy <= 1'b1;
          state <= ADD;
        end
        ADD: begin
          sum[4*idx +: 4] <= add_sum;
          carry_reg <= add_cout;
          idx <= idx + 1'b1;
          if (last) begin
            carry_out <= add_cout;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: vector table, corner sequences and random ops against an arithmetic model
module tb_adder_seq_ctrl;
  localparam int W = 16;
  localparam int NN = W / 4;
  logic clk = 0, n_rst = 0, start = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, carry_out, add_cin, add_cout;
  logic [W-1:0] sum;
  logic [3:0] add_a, add_b, add_sum;
  int checks = 0, errors = 0;
  adder_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .a(a), .b(b), .carry_in(cin),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic cin;
    logic [W-1:0] s;
    logic c;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                    input logic [W-1:0] es, input logic ec, input string nm);
    int k;
    @(negedge clk);
    chk({nm, "_idle_ports"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
    a = ta; b = tb_; cin = tc; start = 1;
    @(negedge clk);
    start = 0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_sum_clr"}, 32'({carry_out, sum}), 32'd0);
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'(NN + 1));
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(carry_out), 32'(ec));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'({busy, done}), 32'd0);
  endtask
  initial begin
    int dn, fk;
    logic [W:0] m;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[5] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0};
    tbl[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({busy, done, carry_out, sum}), 32'd0);
    chk("reset_ports", 32'({add_a, add_b, add_cin}), 32'd0);
    n_rst = 1;
    for (int i = 0; i < 7; i++) op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].c, $sformatf("vec%0d", i));
    // second start two edges after acceptance must be ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 0; start = 1;
    @(negedge clk);
    start = 0; dn = 0; fk = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) begin a = 16'hFFFF; b = 16'hFFFF; cin = 1; start = 1; end
      if (k == 3) start = 0;
      if (k <= 6) chk($sformatf("ign_busy_k%0d", k), 32'(busy), 32'(k <= 5));
      if (done) begin dn++; if (fk == 0) fk = k; end
      if (k == 5) chk("ign_sum", 32'({carry_out, sum}), 32'h5555);
      @(negedge clk);
    end
    chk("ign_done_count", 32'(dn), 32'd1);
    chk("ign_done_cycle", 32'(fk), 32'd5);
    // reset during the third ADD cycle aborts without a done pulse
    a = 16'h1234; b = 16'h4321; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 0;
    @(negedge clk);
    chk("abort_outs", 32'({busy, done, carry_out, sum}), 32'd0);
    n_rst = 1;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "post_abort");
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      m = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
      op(ra, rb, rc, m[W-1:0], m[W], $sformatf("rnd%0d", i));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
